damage_flash_ctrl: RTL

Frame-synchronous blink controller that drives the `enable` input of the downstream colour-substitution stage when a player or enemy takes damage. A one-cycle hit pulse from collision logic arms the block. On the next frame boundary the block produces a square-wave `enable` for a fixed number of VGA frames, then holds a cooldown window. An `invulnerable` flag covers the whole damage window so game logic can ignore repeat hits.

---
 rtl/damage_flash_pkg.sv | 17 +
 rtl/frame_tick_counter.sv | 37 +++
 rtl/damage_flash_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/damage_flash_pkg.sv
// Shared types for the damage flash controller: FSM state encoding and
// a counter-width helper that stays legal when a frame count is zero.
package damage_flash_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FLASH,
        COOLDOWN
    } flash_state_t;

    // $clog2(n+1) bits, but never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Saturating SOF counter with synchronous clear; terminal flags the last
// count of a TERMINAL-frame window (always set when TERMINAL is zero).
module frame_tick_counter
    import damage_flash_pkg::*;
#(
    parameter int TERMINAL = 1
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic tick,
    output logic terminal
);

    localparam int W = cnt_width(TERMINAL);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !terminal) begin
            count <= count + 1'b1;
        end
    end

    generate
        if (TERMINAL > 0) begin : g_term
            assign terminal = (count == W'(TERMINAL - 1));
        end else begin : g_zero
            assign terminal = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/damage_flash_ctrl.sv
// Frame-synchronous damage blink controller. Define DAMAGE_FLASH_RETRIGGER_EN
// to let a hit during FLASH restart the full blink window.
module damage_flash_ctrl
    import damage_flash_pkg::*;
#(
    parameter int FLASH_FRAMES    = 120,
    parameter int TOGGLE_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hitPulse,
    input  logic pause,
    output logic enable,
    output logic flashing,
    output logic invulnerable,
    output logic donePulse
);

    localparam int TW = cnt_width(TOGGLE_FRAMES);
    localparam logic [TW-1:0] TOG_LAST = TW'(TOGGLE_FRAMES - 1);

    flash_state_t  state, next_state;
    logic          next_enable, next_done;
    logic          sof_go, hit_go, retrig;
    logic          frame_tick, frame_term, cool_tick, cool_term;
    logic [TW-1:0] tog_cnt, next_tog;

    // Pause masks both inputs, which freezes every register below.
    assign sof_go = startOfFrame & ~pause;
    assign hit_go = hitPulse & ~pause;

    frame_tick_counter #(.TERMINAL(FLASH_FRAMES)) u_frame_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clear    ((state != FLASH) | retrig),
        .tick     (frame_tick),
        .terminal (frame_term)
    );

    frame_tick_counter #(.TERMINAL(COOLDOWN_FRAMES)) u_cool_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (state != COOLDOWN),
        .tick     (cool_tick),
        .terminal (cool_term)
    );

    always_comb begin
        next_state  = state;
        next_enable = enable;
        next_done   = 1'b0;
        next_tog    = tog_cnt;
        frame_tick  = 1'b0;
        cool_tick   = 1'b0;
        retrig      = 1'b0;
        case (state)
            IDLE: begin
                if (hit_go) next_state = ARM;
            end
            ARM: begin
                if (sof_go) begin
                    next_state  = FLASH;
                    next_enable = 1'b1;
                    next_tog    = '0;
                end
            end
            FLASH: begin
`ifdef DAMAGE_FLASH_RETRIGGER_EN
                if (hit_go) begin
                    retrig      = 1'b1;
                    next_enable = 1'b1;
                    next_tog    = '0;
                end else
`endif
                if (sof_go) begin
                    if (frame_term) begin
                        next_enable = 1'b0;
                        next_done   = 1'b1;
                        next_state  = (COOLDOWN_FRAMES > 0) ? COOLDOWN : IDLE;
                    end else begin
                        frame_tick = 1'b1;
                        if (tog_cnt == TOG_LAST) begin
                            next_enable = ~enable;
                            next_tog    = '0;
                        end else begin
                            next_tog = tog_cnt + 1'b1;
                        end
                    end
                end
            end
            COOLDOWN: begin
                if (sof_go) begin
                    if (cool_term) next_state = IDLE;
                    else           cool_tick  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status flags are decoded from next_state so they register alongside it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            tog_cnt      <= '0;
            enable       <= 1'b0;
            flashing     <= 1'b0;
            invulnerable <= 1'b0;
            donePulse    <= 1'b0;
        end else begin
            state        <= next_state;
            tog_cnt      <= next_tog;
            enable       <= next_enable;
            flashing     <= (next_state == ARM) || (next_state == FLASH);
            invulnerable <= (next_state != IDLE);
            donePulse    <= next_done;
        end
    end

endmodule
